layer_1_relu_serializer: RTL and testbench
==========================================

# layer_1_relu_serializer

Downstream neighbour of the layer-1 bias-add stage. On a `start` pulse it snapshots all 20 signed Q12.4 bias-added accumulators, applies ReLU and requantises each to an unsigned-range 8-bit activation. It then streams the 20 activations one per handshake, in index order, over a valid/ready interface into the layer-2 MAC input.

## Interface
Parameters:
- `SIZE`, 16, width of each accumulator input (signed, two's complement, Q12.4).
- `OUT_SIZE`, 8, width of each output activation.
- `SHIFT`, 4, number of fractional bits dropped during requantisation.

Ports:
- `clk`  input  1  single clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle pulse, driven by the bias-add `done` of the final load; it marks the inputs as valid.
- `layer_1_input_1` .. `layer_1_input_20`  input  SIZE each  accumulator values; sampled only in the `start` cycle.
- `out_data`  output  OUT_SIZE  current activation.
- `out_index`  output  5  neuron index of `out_data`, 0..19.
- `out_valid`  output  1  `out_data`/`out_index` are valid.
- `out_ready`  input  1  consumer accepts the current element.
- `out_last`  output  1  high with `out_valid` when `out_index` is 19.
- `busy`  output  1  high whenever the FSM is in STREAM.
- `overrun`  output  1  sticky flag; set when a `start` is dropped.

## Operation
- Requantisation, per lane, computed on capture with `v` as the signed input:
  - If `v < 0`, the result is 0.
  - Otherwise `q = v >> SHIFT` (truncation, floor).
  - If `q > 2^(OUT_SIZE-1)-1` (127), the result is saturated to 127. Otherwise the result is `q[OUT_SIZE-1:0]`.
- The capture bank holds 20 × OUT_SIZE registers and stores quantised values, not raw accumulators.
- FSM states:
  - IDLE → STREAM on `start`. The 20 lanes are captured in that cycle and `count` is set to 0.
  - STREAM: `out_valid` = 1 and `out_data` = bank[`count`]. On `out_valid && out_ready`:
    - If `count` = 19, go to IDLE.
    - Otherwise `count` increments.
  - With `out_valid` high and `out_ready` low, `out_data`, `out_index` and `out_last` are held stable.
- `start` is honoured only in IDLE. A `start` in STREAM, including the cycle of the final handshake, is ignored and sets `overrun`. The bank and `count` are unaffected.
- `overrun` clears only on reset.
- Reset values: the FSM is in IDLE and `count`=0, and the bank is all 0. Outputs after reset:
  - `out_valid`=0, `out_last`=0, `busy`=0, `overrun`=0.
  - `out_data`=0, `out_index`=0.
- Reset asserted mid-stream aborts immediately: `out_valid` drops asynchronously and the partial stream is discarded.

## Timing
- `start` sampled at edge t → `out_valid`=1 with index 0 from t+1. Capture-to-first-output latency is 1 cycle.
- With `out_ready` held high, one element is transferred per cycle. Indices 0..19 occupy cycles t+1..t+20.
- The final handshake at edge t+20 → `out_valid`=0 and `busy`=0 from t+21. The earliest accepted next `start` is at edge t+21.
- `out_data`, `out_index` and `out_last` are registered. There is no combinational path from `out_ready` to any output.
- `busy` equals `out_valid` in every cycle.

## Structure
- Shared package `layer_1_pkg` holds:
  - the constant `LAYER_1_NEURONS` = 20
  - the index width (5)
  - the state enum {IDLE, STREAM}
  - the default SIZE/OUT_SIZE/SHIFT values, which must match the bias-add stage's Q12.4 format.
- Sub-module `layer_1_relu_quant` is purely combinational, one lane: SIZE in, OUT_SIZE out, parameterised by SHIFT. It is instantiated 20 times in a generate loop ahead of the capture bank.
- The top level contains the FSM, `count`, the bank, the output mux/registers and the overrun logic.

## Test plan
- Quantisation: lanes of 0x0150, 0xFFF0, 0x0FFF, 0x07F0, 0x000F, 0x8000 with `out_ready`=1 → `out_data` 21, 0, 127, 127, 0, 0 at those indices. `out_last` is high only at index 19.
- Back-pressure: `out_ready` toggles 1,0,0,1 repeatedly → outputs are held stable while stalled, exactly 20 transfers occur, and indices 0..19 appear in order with none skipped or duplicated.
- Overrun: a second `start` at index 7, and another in the final-handshake cycle → stream contents are unchanged, `overrun`=1 after the first drop, and a `start` one cycle after `busy` falls is accepted.
- Reset mid-stream: `reset` pulled low at index 10 → `out_valid`, `busy` and `overrun` are 0 immediately, with no clock edge required. After release, a new `start` streams from index 0.
- Back-to-back frames: `start` at t and at t+21 with `out_ready`=1 → 40 contiguous-but-one transfers, the second frame reflects the new inputs, and `overrun` stays 0.

Source files
------------

// File: rtl/layer_1_pkg.sv
// Shared layer-1 constants: neuron count, index width, FSM states, Q12.4 formats.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package layer_1_pkg;

    localparam int LAYER_1_NEURONS = 20;
    localparam int L1_IDX_W        = 5;

    // Accumulator format from the bias-add stage is Q12.4; activations are 8-bit.
    localparam int L1_SIZE     = 16;
    localparam int L1_OUT_SIZE = 8;
    localparam int L1_SHIFT    = 4;

    localparam logic [L1_IDX_W-1:0] L1_LAST_IDX = L1_IDX_W'(LAYER_1_NEURONS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } l1_state_t;

endpackage

// File: rtl/layer_1_relu_quant.sv
// One lane of ReLU plus requantisation: drop SHIFT fractional bits, clamp to signed max.
// Latency: purely combinational.
// Backpressure: none.
module layer_1_relu_quant #(
    parameter int SIZE     = 16,
    parameter int OUT_SIZE = 8,
    parameter int SHIFT    = 4
) (
    input  logic [SIZE-1:0]     acc_i,
    output logic [OUT_SIZE-1:0] act_o
);

    // Largest positive activation, widened so it compares against the full shifted value.
    localparam logic [SIZE-1:0] MAX_Q = SIZE'((1 << (OUT_SIZE - 1)) - 1);

    logic [SIZE-1:0] shifted;

    // Only used for non-negative inputs, so a logical shift is a floor.
    assign shifted = acc_i >> SHIFT;

    // Negative -> 0, too large -> saturate, otherwise keep the low bits.
    always_comb begin
        act_o = '0;
        if (acc_i[SIZE-1]) begin
            act_o = '0;
        end else if (shifted > MAX_Q) begin
            act_o = MAX_Q[OUT_SIZE-1:0];
        end else begin
            act_o = shifted[OUT_SIZE-1:0];
        end
    end

endmodule

// File: rtl/layer_1_relu_serializer.sv
// Captures 20 quantised accumulators on start and streams them in index order over valid/ready.
// Latency: first element valid the cycle after start; one element per cycle with ready held high.
// Backpressure: outputs held while out_ready is low; start outside IDLE is dropped and flags overrun.
module layer_1_relu_serializer
    import layer_1_pkg::*;
#(
    parameter int SIZE     = L1_SIZE,
    parameter int OUT_SIZE = L1_OUT_SIZE,
    parameter int SHIFT    = L1_SHIFT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [SIZE-1:0]     layer_1_input_1,
    input  logic [SIZE-1:0]     layer_1_input_2,
    input  logic [SIZE-1:0]     layer_1_input_3,
    input  logic [SIZE-1:0]     layer_1_input_4,
    input  logic [SIZE-1:0]     layer_1_input_5,
    input  logic [SIZE-1:0]     layer_1_input_6,
    input  logic [SIZE-1:0]     layer_1_input_7,
    input  logic [SIZE-1:0]     layer_1_input_8,
    input  logic [SIZE-1:0]     layer_1_input_9,
    input  logic [SIZE-1:0]     layer_1_input_10,
    input  logic [SIZE-1:0]     layer_1_input_11,
    input  logic [SIZE-1:0]     layer_1_input_12,
    input  logic [SIZE-1:0]     layer_1_input_13,
    input  logic [SIZE-1:0]     layer_1_input_14,
    input  logic [SIZE-1:0]     layer_1_input_15,
    input  logic [SIZE-1:0]     layer_1_input_16,
    input  logic [SIZE-1:0]     layer_1_input_17,
    input  logic [SIZE-1:0]     layer_1_input_18,
    input  logic [SIZE-1:0]     layer_1_input_19,
    input  logic [SIZE-1:0]     layer_1_input_20,
    output logic [OUT_SIZE-1:0] out_data,
    output logic [L1_IDX_W-1:0] out_index,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                overrun
);

    logic [SIZE-1:0]     lane_in [LAYER_1_NEURONS];
    logic [OUT_SIZE-1:0] quant_d [LAYER_1_NEURONS];
    logic [OUT_SIZE-1:0] bank_q  [LAYER_1_NEURONS];

    l1_state_t           state_q;
    logic [L1_IDX_W-1:0] count_q;
    logic [L1_IDX_W-1:0] count_d;
    logic [OUT_SIZE-1:0] out_data_q;
    logic                out_last_q;
    logic                overrun_q;

    assign lane_in[0]  = layer_1_input_1;
    assign lane_in[1]  = layer_1_input_2;
    assign lane_in[2]  = layer_1_input_3;
    assign lane_in[3]  = layer_1_input_4;
    assign lane_in[4]  = layer_1_input_5;
    assign lane_in[5]  = layer_1_input_6;
    assign lane_in[6]  = layer_1_input_7;
    assign lane_in[7]  = layer_1_input_8;
    assign lane_in[8]  = layer_1_input_9;
    assign lane_in[9]  = layer_1_input_10;
    assign lane_in[10] = layer_1_input_11;
    assign lane_in[11] = layer_1_input_12;
    assign lane_in[12] = layer_1_input_13;
    assign lane_in[13] = layer_1_input_14;
    assign lane_in[14] = layer_1_input_15;
    assign lane_in[15] = layer_1_input_16;
    assign lane_in[16] = layer_1_input_17;
    assign lane_in[17] = layer_1_input_18;
    assign lane_in[18] = layer_1_input_19;
    assign lane_in[19] = layer_1_input_20;

    // Quantise ahead of the bank so only OUT_SIZE bits per lane are stored.
    for (genvar g = 0; g < LAYER_1_NEURONS; g++) begin : g_lane
        layer_1_relu_quant #(
            .SIZE     (SIZE),
            .OUT_SIZE (OUT_SIZE),
            .SHIFT    (SHIFT)
        ) u_quant (
            .acc_i (lane_in[g]),
            .act_o (quant_d[g])
        );
    end

    assign count_d = count_q + 1'b1;

    // FSM, capture bank, registered output element and sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < LAYER_1_NEURONS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (state_q == IDLE) begin
            if (start) begin
                state_q    <= STREAM;
                count_q    <= '0;
                bank_q     <= quant_d;
                out_data_q <= quant_d[0];
                out_last_q <= 1'b0;
            end
        end else begin
            // A start while streaming is dropped; the bank keeps the current frame.
            if (start) begin
                overrun_q <= 1'b1;
            end
            if (out_ready) begin
                if (count_q == L1_LAST_IDX) begin
                    state_q    <= IDLE;
                    out_last_q <= 1'b0;
                end else begin
                    count_q    <= count_d;
                    out_data_q <= bank_q[count_d];
                    out_last_q <= (count_d == L1_LAST_IDX);
                end
            end
        end
    end

    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign out_data  = out_data_q;
    assign out_index = count_q;
    assign out_last  = out_last_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_layer_1_relu_serializer.sv
module tb_layer_1_relu_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] lanes [20];
    logic [7:0]  out_data;
    logic [4:0]  out_index;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad   = 0;
    int frame [20];
    bit ovr_exp = 1'b0;

    always #5 clk = ~clk;

    layer_1_relu_serializer dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .layer_1_input_1  (lanes[0]),
        .layer_1_input_2  (lanes[1]),
        .layer_1_input_3  (lanes[2]),
        .layer_1_input_4  (lanes[3]),
        .layer_1_input_5  (lanes[4]),
        .layer_1_input_6  (lanes[5]),
        .layer_1_input_7  (lanes[6]),
        .layer_1_input_8  (lanes[7]),
        .layer_1_input_9  (lanes[8]),
        .layer_1_input_10 (lanes[9]),
        .layer_1_input_11 (lanes[10]),
        .layer_1_input_12 (lanes[11]),
        .layer_1_input_13 (lanes[12]),
        .layer_1_input_14 (lanes[13]),
        .layer_1_input_15 (lanes[14]),
        .layer_1_input_16 (lanes[15]),
        .layer_1_input_17 (lanes[16]),
        .layer_1_input_18 (lanes[17]),
        .layer_1_input_19 (lanes[18]),
        .layer_1_input_20 (lanes[19]),
        .out_data         (out_data),
        .out_index        (out_index),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .busy             (busy),
        .overrun          (overrun)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: Q12.4 value, ReLU, drop 4 fraction bits, clamp to 127.
    function automatic int ref_quant(input logic [15:0] x);
        int v;
        int q;
        v = int'($signed(x));
        if (v < 0) return 0;
        q = v / 16;
        return (q > 127) ? 127 : q;
    endfunction

    function automatic logic [15:0] rand_lane();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(0, 2047));
            2:       return 16'($urandom_range(2000, 2100));
            default: return 16'(-$urandom_range(1, 30000));
        endcase
    endfunction

    task automatic randomize_lanes();
        for (int i = 0; i < 20; i++) lanes[i] = rand_lane();
    endtask

    // Drive a start with the current lanes; returns at edge+1 where index 0 should be visible.
    task automatic do_start();
        for (int i = 0; i < 20; i++) frame[i] = ref_quant(lanes[i]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        randomize_lanes();
    endtask

    // Consume one frame. mode 0: ready always, 1: 1,0,0,1 pattern, 2: random.
    // stray_idx >= 0 drives a dropped start at that index; stray_last drives one on the final handshake.
    // abort_idx >= 0 asserts reset when that index is presented.
    task automatic stream_frame(input int mode, input int stray_idx, input bit stray_last,
                                input int abort_idx);
        int  e = 0;
        int  cyc = 0;
        bit  rdy;
        bit  stray_done = 1'b0;
        while (e < 20 && cyc < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (e == abort_idx) begin
                reset = 1'b0;
                #1;
                chk("rst_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_ovr", overrun, 0);
                ovr_exp = 1'b0;
                out_ready = 1'b0;
                @(posedge clk); @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                chk("rst_idle", out_valid, 0);
                return;
            end
            out_ready = rdy;
            chk("valid", out_valid, 1);
            chk("busy", busy, out_valid);
            chk("index", out_index, e);
            chk("data", out_data, frame[e]);
            chk("last", out_last, (e == 19));
            chk("ovr", overrun, ovr_exp);
            if ((e == stray_idx && !stray_done) || (stray_last && e == 19 && rdy)) begin
                start = 1'b1;
                stray_done = 1'b1;
                randomize_lanes();
            end
            if (rdy) e++;
            @(posedge clk); #1;
            if (start) ovr_exp = 1'b1;
            start = 1'b0;
            cyc++;
        end
        chk("frame_done", e, 20);
        out_ready = 1'b0;
        chk("end_valid", out_valid, 0);
        chk("end_busy", busy, 0);
        chk("end_ovr", overrun, ovr_exp);
    endtask

    initial begin
        randomize_lanes();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_last", out_last, 0);
        chk("reset_ovr", overrun, 0);
        chk("reset_data", out_data, 0);
        chk("reset_index", out_index, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_valid", out_valid, 0);

        // Directed quantisation corner values mixed with random lanes.
        lanes[0]  = 16'h0150;
        lanes[3]  = 16'hFFF0;
        lanes[5]  = 16'h0FFF;
        lanes[8]  = 16'h07F0;
        lanes[12] = 16'h000F;
        lanes[19] = 16'h8000;
        do_start();
        stream_frame(0, -1, 1'b0, -1);

        // Back-pressure: ready 1,0,0,1 repeating, then random ready.
        do_start();
        stream_frame(1, -1, 1'b0, -1);
        do_start();
        stream_frame(2, -1, 1'b0, -1);

        // Dropped starts at index 7 and on the final handshake; next start right after busy falls.
        do_start();
        stream_frame(0, 7, 1'b1, -1);
        do_start();
        stream_frame(1, -1, 1'b0, -1);

        // Reset mid-stream at index 10, then a fresh frame from index 0.
        do_start();
        stream_frame(0, -1, 1'b0, 10);
        do_start();
        stream_frame(0, -1, 1'b0, -1);

        // Back-to-back frames with ready held high.
        do_start();
        stream_frame(0, -1, 1'b0, -1);
        do_start();
        stream_frame(0, -1, 1'b0, -1);

        // A handful of random frames.
        for (int f = 0; f < 6; f++) begin
            do_start();
            stream_frame(2, -1, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
